// File: rtl/mvm_requant_out_pkg.sv
// Shared types and the requantisation helper for the MVM output stage.
// Converts signed 16-bit MVM results into signed 8-bit elements for the next layer.
package mvm_requant_out_pkg;

  localparam int RESULT_W = 16;
  localparam int ELEM_W   = 8;

  typedef logic signed [RESULT_W-1:0] result_t;
  typedef logic signed [ELEM_W-1:0]   elem_t;

  localparam int SAT_MIN = -128;
  localparam int SAT_MAX = 127;

  localparam result_t RES_MIN = result_t'(SAT_MIN);
  localparam result_t RES_MAX = result_t'(SAT_MAX);

  // One FIFO entry: the requantised element plus its end-of-group flag.
  typedef struct packed {
    logic  last;
    elem_t data;
  } out_word_t;

  localparam int OUT_WORD_W = $bits(out_word_t);

  typedef struct packed {
    elem_t value;
    logic  sat;
  } requant_t;

  // Floor shift, optional ReLU, then clamp. ReLU zeroing is not counted as saturation.
  function automatic requant_t requant(input result_t x, input int shift, input logic relu);
    requant_t r;
    result_t  y;
    y = x >>> shift;
    if (relu && y[RESULT_W-1]) begin
      y = '0;
    end
    r.sat   = 1'b0;
    r.value = y[ELEM_W-1:0];
    if (y > RES_MAX) begin
      r.value = RES_MAX[ELEM_W-1:0];
      r.sat   = 1'b1;
    end else if (y < RES_MIN) begin
      r.value = RES_MIN[ELEM_W-1:0];
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mvm_requant_out_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// The head entry is read straight from storage at rd_ptr, so it holds while no pop occurs.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/mvm_requant_out.sv
// Requantises MVM results to 8-bit elements, tags group ends and buffers them for the next layer.
// Handshake: a beat moves on any posedge where valid && ready; ready never looks at valid.
module mvm_requant_out
  import mvm_requant_out_pkg::*;
#(
  parameter int K     = 2,
  parameter int SHIFT = 4,
  parameter int RELU  = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [15:0]   data_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    data_out,
  output logic          m_last,
  output logic          sat
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (K > 1) ? $clog2(K) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(K - 1);

  logic [GW-1:0] grp;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  requant_t      rq;
  out_word_t     wr_word;
  out_word_t     head;

  // Ready/valid come only from the registered count: no path from m_ready to s_ready.
  assign s_ready = (count < CW'(DEPTH));
  assign m_valid = (count != '0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  assign rq           = requant(result_t'(data_in), SHIFT, (RELU != 0));
  assign wr_word.data = rq.value;
  assign wr_word.last = (grp == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      grp <= '0;
    end else if (push) begin
      grp <= (grp == LAST_IDX) ? '0 : grp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat <= 1'b0;
    end else if (push && rq.sat) begin
      sat <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_word),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Storage is not reset, so the last flag is qualified to read 0 while empty.
  assign data_out = head.data;
  assign m_last   = m_valid && head.last;

  a_ready_full:  assert property (@(posedge clk) disable iff (reset) s_ready == !full);
  a_valid_empty: assert property (@(posedge clk) disable iff (reset) m_valid == !empty);

endmodule

// File: tb/tb_mvm_requant_out.sv
// Directed and backpressure bench for mvm_requant_out (K=2, SHIFT=4, DEPTH=4; RELU=1 and RELU=0).
module tb_mvm_requant_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready, m_valid, m_ready, m_last, sat;
  logic [15:0] data_in;
  logic [7:0]  data_out;
  logic        s_valid_nr, s_ready_nr, m_valid_nr, m_ready_nr, m_last_nr, sat_nr;
  logic [15:0] data_in_nr;
  logic [7:0]  data_out_nr;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  mvm_requant_out #(.K(2), .SHIFT(4), .RELU(1), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out), .m_last(m_last), .sat(sat)
  );

  mvm_requant_out #(.K(2), .SHIFT(4), .RELU(0), .DEPTH(4)) dut_nr (
    .clk(clk), .reset(reset), .s_valid(s_valid_nr), .s_ready(s_ready_nr), .data_in(data_in_nr),
    .m_valid(m_valid_nr), .m_ready(m_ready_nr), .data_out(data_out_nr), .m_last(m_last_nr),
    .sat(sat_nr)
  );

  // Reference requantisation by integer floor division.
  function automatic logic [7:0] model_rq(input logic [15:0] x, input bit relu, output bit s);
    int v, q;
    v = $signed(x);
    if (v >= 0) q = v / 16;
    else q = -((-v + 15) / 16);
    s = 1'b0;
    if (relu && q < 0) q = 0;
    if (q > 127) begin q = 127; s = 1'b1; end
    if (q < -128) begin q = -128; s = 1'b1; end
    return 8'(q);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s_valid_nr = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b want 0", m_last); else pass_cnt++;
    total_cnt++; if (sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat); else pass_cnt++;
    total_cnt++; if (m_valid_nr !== 1'b0) $display("FAIL reset_m_valid_nr: got %b want 0", m_valid_nr); else pass_cnt++;
    total_cnt++; if (s_ready_nr !== 1'b1) $display("FAIL reset_s_ready_nr: got %b want 1", s_ready_nr); else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    m_ready = 1'b1;
    s_valid = 1'b1;
    data_in = 16'd256;
    step();
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL basic_valid0: got %b want 1", m_valid); else pass_cnt++;
    total_cnt++; if (data_out !== 8'd16) $display("FAIL basic_data0: got %0d want 16", data_out); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b0) $display("FAIL basic_last0: got %b want 0", m_last); else pass_cnt++;
    data_in = 16'd48;
    step();
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL basic_valid1: got %b want 1", m_valid); else pass_cnt++;
    total_cnt++; if (data_out !== 8'd3) $display("FAIL basic_data1: got %0d want 3", data_out); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b1) $display("FAIL basic_last1: got %b want 1", m_last); else pass_cnt++;
    s_valid = 1'b0;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (sat !== 1'b0) $display("FAIL basic_sat: got %b want 0", sat); else pass_cnt++;
  endtask

  task automatic test_relu();
    do_reset();
    m_ready = 1'b1;
    s_valid = 1'b1;
    data_in = 16'hFFD8;
    step();
    total_cnt++; if (data_out !== 8'd0) $display("FAIL relu_neg40: got %0d want 0", data_out); else pass_cnt++;
    data_in = 16'h8000;
    step();
    total_cnt++; if (data_out !== 8'd0) $display("FAIL relu_min: got %0d want 0", data_out); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b1) $display("FAIL relu_last: got %b want 1", m_last); else pass_cnt++;
    s_valid = 1'b0;
    step();
    total_cnt++; if (sat !== 1'b0) $display("FAIL relu_sat: got %b want 0", sat); else pass_cnt++;
    m_ready_nr = 1'b1;
    s_valid_nr = 1'b1;
    data_in_nr = 16'hFFD8;
    step();
    total_cnt++; if (data_out_nr !== 8'hFD) $display("FAIL norelu_neg40: got %h want fd", data_out_nr); else pass_cnt++;
    total_cnt++; if (sat_nr !== 1'b0) $display("FAIL norelu_sat0: got %b want 0", sat_nr); else pass_cnt++;
    data_in_nr = 16'hF800;
    step();
    total_cnt++; if (data_out_nr !== 8'h80) $display("FAIL norelu_m2048: got %h want 80", data_out_nr); else pass_cnt++;
    total_cnt++; if (sat_nr !== 1'b0) $display("FAIL norelu_sat_edge: got %b want 0", sat_nr); else pass_cnt++;
    data_in_nr = 16'hF7FF;
    step();
    total_cnt++; if (data_out_nr !== 8'h80) $display("FAIL norelu_m2049: got %h want 80", data_out_nr); else pass_cnt++;
    total_cnt++; if (sat_nr !== 1'b1) $display("FAIL norelu_sat_neg: got %b want 1", sat_nr); else pass_cnt++;
    data_in_nr = 16'h8000;
    step();
    total_cnt++; if (data_out_nr !== 8'h80) $display("FAIL norelu_min: got %h want 80", data_out_nr); else pass_cnt++;
    s_valid_nr = 1'b0;
    step();
    total_cnt++; if (sat_nr !== 1'b1) $display("FAIL norelu_sat_hold: got %b want 1", sat_nr); else pass_cnt++;
  endtask

  task automatic test_sat_sticky();
    do_reset();
    m_ready = 1'b1;
    s_valid = 1'b1;
    data_in = 16'd2032;
    step();
    total_cnt++; if (data_out !== 8'd127) $display("FAIL sat_2032: got %0d want 127", data_out); else pass_cnt++;
    total_cnt++; if (sat !== 1'b0) $display("FAIL sat_2032_flag: got %b want 0", sat); else pass_cnt++;
    data_in = 16'd2047;
    step();
    total_cnt++; if (data_out !== 8'd127) $display("FAIL sat_2047: got %0d want 127", data_out); else pass_cnt++;
    total_cnt++; if (sat !== 1'b0) $display("FAIL sat_2047_flag: got %b want 0", sat); else pass_cnt++;
    data_in = 16'd2048;
    step();
    total_cnt++; if (data_out !== 8'd127) $display("FAIL sat_2048: got %0d want 127", data_out); else pass_cnt++;
    total_cnt++; if (sat !== 1'b1) $display("FAIL sat_2048_flag: got %b want 1", sat); else pass_cnt++;
    data_in = 16'h7FFF;
    step();
    total_cnt++; if (data_out !== 8'd127) $display("FAIL sat_7fff: got %0d want 127", data_out); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      data_in = 16'(i * 16);
      step();
      total_cnt++;
      if (data_out !== 8'(i) || m_last !== i[0])
        $display("FAIL sat_follow%0d: got %0d/%b want %0d/%b", i, data_out, m_last, i, i[0]);
      else pass_cnt++;
    end
    s_valid = 1'b0;
    step();
    total_cnt++; if (sat !== 1'b1) $display("FAIL sat_sticky: got %b want 1", sat); else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_in = 16'(i * 16);
      step();
    end
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL full_s_ready: got %b want 0", s_ready); else pass_cnt++;
    data_in = 16'd80;
    step();
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL full_hold_ready: got %b want 0", s_ready); else pass_cnt++;
    total_cnt++; if (data_out !== 8'd1 || m_last !== 1'b0) $display("FAIL full_head_stall: got %0d/%b want 1/0", data_out, m_last); else pass_cnt++;
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    total_cnt++; if (data_out !== 8'd2 || m_last !== 1'b1) $display("FAIL full_out2: got %0d/%b want 2/1", data_out, m_last); else pass_cnt++;
    step();
    total_cnt++; if (data_out !== 8'd3 || m_last !== 1'b0) $display("FAIL full_out3: got %0d/%b want 3/0", data_out, m_last); else pass_cnt++;
    step();
    total_cnt++; if (data_out !== 8'd4 || m_last !== 1'b1) $display("FAIL full_out4: got %0d/%b want 4/1", data_out, m_last); else pass_cnt++;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL full_no_fifth: got %b want 0", m_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int sent = 0, recv = 0, cycles = 0, bad = 0;
    bit s, sat_exp = 1'b0, stall = 1'b0, grp = 1'b0;
    logic [8:0] held = '0;
    logic [15:0] w;
    do_reset();
    exp_q.delete();
    while (recv < 200 && cycles < 5000) begin
      cycles++;
      if (sent < 200) begin
        s_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: w = 16'h8000 + 16'($urandom_range(0, 3));
          1: w = 16'h7FF0 + 16'($urandom_range(0, 15));
          default: w = 16'($urandom_range(0, 65535));
        endcase
        data_in = w;
      end else begin
        s_valid = 1'b0;
      end
      m_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (s_ready !== (exp_q.size() < 4)) bad++;
      if (m_valid !== (exp_q.size() != 0)) bad++;
      if (stall && {m_last, data_out} !== held) bad++;
      if (m_valid && m_ready && exp_q.size() != 0) begin
        if ({m_last, data_out} !== exp_q[0]) begin
          $display("FAIL stream_word%0d: got %0d/%b want %0d/%b", recv, data_out, m_last, exp_q[0][7:0], exp_q[0][8]);
          bad++;
        end
        void'(exp_q.pop_front());
        recv++;
      end
      stall = m_valid && !m_ready;
      held = {m_last, data_out};
      if (s_valid && s_ready) begin
        exp_q.push_back({grp, model_rq(data_in, 1'b1, s)});
        if (s) sat_exp = 1'b1;
        grp = ~grp;
        sent++;
      end
      step();
    end
    s_valid = 1'b0;
    total_cnt++; if (bad != 0) $display("FAIL stream_errors: got %0d want 0", bad); else pass_cnt++;
    total_cnt++; if (recv != 200) $display("FAIL stream_count: got %0d want 200", recv); else pass_cnt++;
    total_cnt++; if (sat !== sat_exp) $display("FAIL stream_sat: got %b want %b", sat, sat_exp); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    data_in = 16'd16;
    step();
    data_in = 16'h7FFF;
    step();
    data_in = 16'd32;
    step();
    s_valid = 1'b0;
    total_cnt++; if (sat !== 1'b1) $display("FAIL mid_sat_before: got %b want 1", sat); else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_m_valid: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL mid_s_ready: got %b want 1", s_ready); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b0) $display("FAIL mid_m_last: got %b want 0", m_last); else pass_cnt++;
    total_cnt++; if (sat !== 1'b0) $display("FAIL mid_sat: got %b want 0", sat); else pass_cnt++;
    m_ready = 1'b1;
    s_valid = 1'b1;
    data_in = 16'd48;
    step();
    total_cnt++; if (data_out !== 8'd3 || m_last !== 1'b0) $display("FAIL mid_first: got %0d/%b want 3/0", data_out, m_last); else pass_cnt++;
    data_in = 16'd64;
    step();
    total_cnt++; if (data_out !== 8'd4 || m_last !== 1'b1) $display("FAIL mid_second: got %0d/%b want 4/1", data_out, m_last); else pass_cnt++;
    s_valid = 1'b0;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_drain: got %b want 0", m_valid); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;
    s_valid_nr = 1'b0;
    m_ready_nr = 1'b0;
    data_in_nr = '0;
    test_reset();
    test_basic();
    test_relu();
    test_sat_sticky();
    test_full();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mvm_requant_out.md
MVM_REQUANT_OUT -- requirements
Module: mvm_requant_out

Interface
REQ-001 Parameter K, default 2, result-vector length; m_last marks each group of K outputs.
REQ-002 Parameter SHIFT, default 4, arithmetic right-shift applied to each 16-bit result.
REQ-003 Parameter RELU, default 1, when 1 negative shifted values clamp to 0.
REQ-004 Parameter DEPTH, default 4, output FIFO entries (power of two, ≥2).
REQ-005 clk  input  1  clock, all logic on posedge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 s_valid  input  1  upstream 16-bit result valid.
REQ-008 s_ready  output  1  block can accept a result this cycle.
REQ-009 data_in  input  16  signed matrix-vector result from the upstream MVM stage.
REQ-010 m_valid  output  1  data_out/m_last valid.
REQ-011 m_ready  input  1  downstream accepts data_out.
REQ-012 data_out  output  8  signed requantised element, usable as next-layer vector input.
REQ-013 m_last  output  1  data_out is element K-1 of its group.
REQ-014 sat  output  1  sticky: some accepted result saturated.

Function
REQ-015 Input transfer occurs on any posedge with s_valid && s_ready; output transfer on m_valid && m_ready.
REQ-016 s_ready SHALL equal (count < DEPTH), combinational from registered FIFO count only, never from s_valid.
REQ-017 When full, s_ready is 0 even if a pop occurs the same cycle; no push that cycle.
REQ-018 m_valid SHALL equal (count != 0); data_out and m_last driven from FIFO head register, stable while m_valid && !m_ready.
REQ-019 Requant per accepted word: y = data_in >>> SHIFT (floor, sign-extended); if RELU and y<0 then y=0; clamp to [-128,127].
REQ-020 Requant result and its last bit written to FIFO in the accept cycle; visible on m_valid the next cycle (latency 1 when empty).
REQ-021 Group counter (0..K-1) increments per accepted input, wraps K-1→0; last bit = (counter == K-1) at accept.
REQ-022 sat sets on any accepted word where the clamp changed the value (positive or negative clamp; RELU zeroing is not saturation); clears only on reset.
REQ-023 Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
REQ-024 Pop while empty or push while full SHALL never occur; pointers wrap modulo DEPTH.
REQ-025 data_out is don't-care when m_valid is 0.

Reset
REQ-026 On reset: count, read/write pointers, group counter = 0; sat = 0; hence m_valid = 0, m_last = 0, s_ready = 1 the following cycle.
REQ-027 Reset mid-stream discards all buffered entries and any partial group; next accepted word is element 0 of a new group.
REQ-028 FIFO data storage need not be reset.

Structure
REQ-029 Shared package holds the 16-bit result type, 8-bit element type, and saturation limits (-128, 127).
REQ-030 One sub-module, sync_fifo (width 9 = data+last, depth DEPTH, push/pop/full/empty/count); requant and group counter stay in the top.
REQ-031 Target 120-400 lines RTL; no latches, no combinational path from m_ready to s_ready.

Verification
REQ-032 SHIFT=4,RELU=1,K=2: inputs 256, 48 with m_ready=1 -> outputs 16 (m_last=0), 3 (m_last=1), each one cycle after accept, sat=0.
REQ-033 RELU=0: input -40 -> -3; input 0x8000 -> -128, sat=1; RELU=1: -40 -> 0, sat unchanged.
REQ-034 Input 0x7FFF -> 127, sat=1 and stays 1 through 10 further unsaturated words.
REQ-035 m_ready=0, push 4 words -> s_ready=0 after the 4th, 5th s_valid word not accepted; release m_ready -> 4 words out in order, m_last on 2nd and 4th.
REQ-036 Random s_valid/m_ready backpressure, 200 words -> output sequence equals reference model, head stable under stall, m_last every K.
REQ-037 Reset asserted with 3 words buffered and group counter=1 -> m_valid=0, s_ready=1 next cycle; next group starts at element 0.
